// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage, the instruction memory, the redirect
// source and decode.
//
// Handshake: decode takes the head entry on a rising edge exactly when
// if_valid && id_ready are both high in that cycle. if_valid does not wait
// for id_ready. A redirect in the same cycle forces if_valid low, so no
// transfer happens in a redirect cycle.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        misalign;
  logic [31:0] fetch_count;
  logic        state_dbg;  // 1 while the fetch FSM is in FAULT

  modport master (
    output imem_addr, if_valid, if_pc, if_inst, misalign, fetch_count, state_dbg,
    input  imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_addr, if_valid, if_pc, if_inst, misalign, fetch_count, state_dbg,
    output imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: a PC register feeding a 2-entry {pc, inst} FIFO
// toward decode. Misaligned redirects park the stage in FAULT.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  fetch_stage_if.master bus
);

  typedef enum logic {
    FETCH = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] fifo_pc   [2];
  logic [31:0] fifo_inst [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  occ;
  logic        misalign_q;
  logic [31:0] fetch_count_q;
  logic        redirect_aligned;
  logic        push;
  logic        pop;

  always_comb begin
    state_next       = state;
    redirect_aligned = (bus.redirect_pc[1:0] == 2'b00);
    push             = 1'b0;
    pop              = 1'b0;
    if (bus.redirect_valid) begin
      state_next = redirect_aligned ? FETCH : FAULT;
    end else begin
      // Push decision uses start-of-cycle occupancy: a full FIFO never
      // refills in the same cycle it pops.
      push = (state == FETCH) && (occ != 2'd2);
      pop  = (occ != 2'd0) && bus.id_ready;
    end
  end

  assign bus.imem_addr   = pc;
  assign bus.if_valid    = (occ != 2'd0) && !bus.redirect_valid;
  assign bus.if_pc       = fifo_pc[rd_ptr];
  assign bus.if_inst     = fifo_inst[rd_ptr];
  assign bus.misalign    = misalign_q;
  assign bus.fetch_count = fetch_count_q;
  assign bus.state_dbg   = (state == FAULT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      occ           <= 2'd0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      misalign_q    <= 1'b0;
      fetch_count_q <= 32'd0;
    end else if (bus.redirect_valid) begin
      occ        <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      pc         <= {bus.redirect_pc[31:2], 2'b00};
      misalign_q <= !redirect_aligned;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]   <= pc;
        fifo_inst[wr_ptr] <= bus.imem_rdata;
        wr_ptr            <= ~wr_ptr;
        pc                <= pc + 32'd4;
      end
      if (pop) begin
        rd_ptr        <= ~rd_ptr;
        fetch_count_q <= fetch_count_q + 32'd1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two instances (default RESET_PC and a wrap-around
// RESET_PC) share stimulus and are checked against an occupancy/head model.
module tb_fetch_stage;

  localparam logic [31:0] RP0 = 32'h0000_0000;
  localparam logic [31:0] RP1 = 32'hFFFF_FFF8;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  fetch_stage_if bus0 ();
  fetch_stage_if bus1 ();

  fetch_stage #(.RESET_PC(RP0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fetch_stage #(.RESET_PC(RP1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h1000_0000 + {2'b00, addr[31:2]};
  endfunction

  assign bus0.imem_rdata = mem_word(bus0.imem_addr);
  assign bus1.imem_rdata = mem_word(bus1.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the FIFO always holds consecutive words starting at
  // m_head, so it is fully described by head address and occupancy.
  logic [31:0] m_pc   [2];
  logic [31:0] m_head [2];
  logic [31:0] m_cnt  [2];
  int          m_occ  [2];
  bit          m_fault[2];
  bit          m_mis  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input int d, input logic r, input logic rv,
                              input logic [31:0] rpc, input logic rdy);
    if (r) begin
      m_pc[d] = (d == 0) ? RP0 : RP1;
      m_occ[d] = 0; m_fault[d] = 0; m_mis[d] = 0; m_cnt[d] = 0;
    end else if (rv) begin
      m_occ[d]   = 0;
      m_pc[d]    = rpc & 32'hFFFF_FFFC;
      m_mis[d]   = (rpc[1:0] != 2'b00);
      m_fault[d] = m_mis[d];
    end else begin
      bit can_push;
      can_push = !m_fault[d] && (m_occ[d] < 2);
      if (m_occ[d] != 0 && rdy) begin
        m_head[d] += 4; m_occ[d]--; m_cnt[d]++;
      end
      if (can_push) begin
        if (m_occ[d] == 0) m_head[d] = m_pc[d];
        m_occ[d]++;
        m_pc[d] += 4;
      end
    end
  endtask

  task automatic check_dut(input int d, input logic rv, input logic [31:0] addr,
                           input logic v, input logic [31:0] pc, input logic [31:0] inst,
                           input logic mis, input logic [31:0] cnt, input logic st);
    logic exp_v;
    exp_v = (m_occ[d] != 0) && !rv;
    chk($sformatf("d%0d_imem_addr", d), addr, m_pc[d]);
    chk($sformatf("d%0d_if_valid", d), {31'd0, v}, {31'd0, exp_v});
    chk($sformatf("d%0d_misalign", d), {31'd0, mis}, {31'd0, m_mis[d]});
    chk($sformatf("d%0d_fetch_count", d), cnt, m_cnt[d]);
    chk($sformatf("d%0d_state", d), {31'd0, st}, {31'd0, m_fault[d]});
    if (exp_v) begin
      chk($sformatf("d%0d_if_pc", d), pc, m_head[d]);
      chk($sformatf("d%0d_if_inst", d), inst, mem_word(m_head[d]));
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic r, input logic rv, input logic [31:0] rpc,
                      input logic rdy, input bit check_en = 1);
    rst = r;
    bus0.redirect_valid = rv; bus0.redirect_pc = rpc; bus0.id_ready = rdy;
    bus1.redirect_valid = rv; bus1.redirect_pc = rpc; bus1.id_ready = rdy;
    #1;
    if (check_en) begin
      check_dut(0, rv, bus0.imem_addr, bus0.if_valid, bus0.if_pc, bus0.if_inst,
                bus0.misalign, bus0.fetch_count, bus0.state_dbg);
      check_dut(1, rv, bus1.imem_addr, bus1.if_valid, bus1.if_pc, bus1.if_inst,
                bus1.misalign, bus1.fetch_count, bus1.state_dbg);
    end
    @(posedge clk);
    model_update(0, r, rv, rpc, rdy);
    model_update(1, r, rv, rpc, rdy);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rpc;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus0.redirect_valid = 1'b0; bus0.redirect_pc = 32'd0; bus0.id_ready = 1'b0;
    bus1.redirect_valid = 1'b0; bus1.redirect_pc = 32'd0; bus1.id_ready = 1'b0;
    @(negedge clk);

    // Reset: the first edge establishes state, later cycles are checked.
    step(1, 0, 0, 0, 0);
    step(1, 1, 32'h44, 1);

    // Streaming with decode always ready; dut1 wraps past 32'hFFFF_FFFC.
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    chk("stream_count5", bus0.fetch_count, 32'd5);

    // Stall: occupancy saturates at 2 and the PC holds at 8.
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("stall_addr8", bus0.imem_addr, 32'h8);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

    // Redirect while full.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(0, 1, 32'h40, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

    // Misaligned redirect, idle in FAULT, then recover with an aligned one.
    step(0, 1, 32'h42, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
    chk("fault_misalign", {31'd0, bus0.misalign}, 32'd1);
    step(0, 1, 32'h80, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

    // Reset colliding with a redirect while full.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 1, 32'h44, 0);
    chk("rst_over_redirect_addr", bus0.imem_addr, RP0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rpc = ($urandom_range(0, 1) == 1 ? 32'hFFFF_FF00 : 32'h0000_0000)
          + (32'($urandom_range(0, 63)) << 2)
          + (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0), rpc,
           ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 imem_addr  output  32  word fetch address, driven combinationally from the PC register.
REQ-005 imem_rdata  input  32  instruction word at imem_addr, valid in the same cycle (combinational memory read).
REQ-006 redirect_valid  input  1  branch/jump/trap redirect from a later stage.
REQ-007 redirect_pc  input  32  redirect target.
REQ-008 id_ready  input  1  decode accepts the head instruction this cycle.
REQ-009 if_valid  output  1  head instruction present for decode.
REQ-010 if_pc  output  32  PC of the head instruction.
REQ-011 if_inst  output  32  head instruction word.
REQ-012 misalign  output  1  sticky flag: last redirect target was not word-aligned.
REQ-013 fetch_count  output  32  number of instructions handed to decode.

Function
REQ-014 The block SHALL hold a PC register and a 2-entry FIFO of {pc, inst} pairs.
REQ-015 The FSM SHALL have two states: FETCH and FAULT.
REQ-016 imem_addr SHALL equal the PC register in every cycle.
REQ-017 In FETCH, with no redirect and FIFO occupancy < 2 at the start of the cycle, the block SHALL push {PC, imem_rdata} and set PC <= PC + 4.
REQ-018 With occupancy == 2 at the start of the cycle, no push SHALL occur, even if a pop occurs in the same cycle, and PC SHALL hold.
REQ-019 PC + 4 SHALL wrap modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-020 if_valid SHALL be (occupancy != 0) AND NOT redirect_valid; if_pc and if_inst SHALL present the FIFO head.
REQ-021 A pop SHALL occur when if_valid && id_ready; the head SHALL then advance, and fetch_count SHALL increment by 1, wrapping modulo 2^32.
REQ-022 Simultaneous push and pop at occupancy 1 SHALL leave occupancy 1, with the new entry at the head on the next cycle.
REQ-023 On redirect_valid == 1 and redirect_pc[1:0] == 2'b00:
  - the FIFO SHALL be flushed (occupancy 0);
  - no push and no pop SHALL occur;
  - PC <= redirect_pc;
  - misalign <= 0;
  - state <= FETCH.
REQ-024 On redirect_valid == 1 and redirect_pc[1:0] != 2'b00:
  - the FIFO SHALL be flushed;
  - PC <= {redirect_pc[31:2], 2'b00};
  - misalign <= 1;
  - state <= FAULT.
REQ-025 In FAULT, the block SHALL perform no pushes; pops of remaining entries cannot occur because the FIFO was flushed. The only exits SHALL be an aligned redirect (REQ-023) or reset.
REQ-026 Redirect SHALL take priority over push and pop in the same cycle.
REQ-027 First push after an aligned redirect SHALL occur in the cycle after the redirect, fetching redirect_pc; if_valid SHALL rise one cycle after that push (two cycles after the redirect).
REQ-028 Throughput with id_ready held high SHALL be one instruction per cycle after the initial one-cycle fill.

Reset
REQ-029 While rst == 1 on a rising edge, the block SHALL set:
  - PC <= RESET_PC;
  - occupancy <= 0;
  - state <= FETCH;
  - misalign <= 0;
  - fetch_count <= 0.
  rst SHALL override redirect_valid.
REQ-030 During and one cycle after reset, if_valid SHALL be 0; imem_addr SHALL equal RESET_PC from the first cycle after reset.
REQ-031 Reset asserted mid-stream SHALL discard all FIFO contents; no entry fetched before reset SHALL reach decode.

Verification
REQ-032 Reset, memory word i = 32'h1000_0000 + i, id_ready = 1 for 6 cycles -> decode receives pc 0, 4, 8, 12, 16 with matching inst values in consecutive cycles, and fetch_count = 5.
REQ-033 id_ready = 0 for 4 cycles, then 1 -> occupancy saturates at 2, PC holds at 8 and imem_addr = 8 while stalled, then decode receives pc 0, 4, 8 in order with none lost or duplicated.
REQ-034 Redirect to 32'h0000_0040 while FIFO is full -> if_valid = 0 in the redirect cycle, next if_pc = 32'h40 two cycles later, and no stale pc 0x8 or 0xC delivered.
REQ-035 Redirect to 32'h0000_0042 -> misalign = 1, no if_valid for 10 cycles; then redirect to 32'h0000_0080 -> misalign = 0 and if_pc = 32'h80 two cycles later.
REQ-036 RESET_PC = 32'hFFFF_FFF8, id_ready = 1 -> delivered pcs FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-037 rst asserted with occupancy 2 and redirect_valid = 1 in the same cycle -> after release, imem_addr = RESET_PC, fetch_count = 0, misalign = 0, and the first delivered pc = RESET_PC.
